// File: rtl/iob_timer_mc_if.sv
// iob_timer_mc_if: native iob bus bundle for the timer.
// master drives the request, slave returns ready/rdata.
interface iob_timer_mc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/iob_timer_mc.sv
// iob_timer_mc: multi-channel up-counter timer on the iob bus.
// Define TIMER_PRESC_EN to add an 8-bit prescaler per channel.
module iob_timer_mc #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = $clog2(N_CH) + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  iob_timer_mc_if.slave   bus,
  output logic [N_CH-1:0] irq
);
  localparam int SW = DATA_W / 8;

  logic [ADDR_W-1:0] ch_idx;
  logic [1:0]        reg_sel;
  logic              wr;
  logic [DATA_W-1:0] bmask;
  logic [DATA_W-1:0] wd_m;
  logic [DATA_W-1:0] rd_mux;

  logic [N_CH-1:0][DATA_W-1:0] rd_ch;

  assign ch_idx  = bus.address >> 2;
  assign reg_sel = bus.address[1:0];
  assign wr      = bus.valid && (|bus.wstrb);
  assign wd_m    = bus.wdata & bmask;

  // expand byte enables into a bit mask
  always_comb begin
    bmask = '0;
    for (int i = 0; i < SW; i++)
      bmask[8*i +: 8] = {8{bus.wstrb[i]}};
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic             hit;
    logic             run;
    logic             mode;
    logic             ie;
    logic             m_f;
    logic             o_f;
    logic [7:0]       presc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cmp;
    logic             clr;
    logic             tick;
    logic             adv;
    logic             match;
    logic [1:0]       w1c;
    logic [15:0]      ctrl_v;
    logic [DATA_W-1:0] rd_v;

    assign hit   = wr && (ch_idx == ADDR_W'(c));
    assign clr   = hit && reg_sel == 2'd0
                && bus.wstrb[0] && bus.wdata[1];
    assign adv   = tick && !clr;
    assign match = cnt == cmp;
    assign w1c   = (hit && reg_sel == 2'd3)
                 ? wd_m[1:0] : 2'b00;

`ifdef TIMER_PRESC_EN
    logic [7:0] pcnt;
    logic       term;

    assign term = pcnt >= presc;
    assign tick = run && term;

    // prescaler counts enabled cycles, cleared by CLR
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   pcnt <= '0;
      else if (clr) pcnt <= '0;
      else if (run) pcnt <= term ? 8'd0 : pcnt + 8'd1;
    end

    // prescale divisor from CTRL byte 1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        presc <= '0;
      else if (hit && reg_sel == 2'd0 && bus.wstrb[1])
        presc <= bus.wdata[15:8];
    end
`else
    assign tick  = run;
    assign presc = 8'd0;
`endif

    // stored CTRL bits; CLR is a strobe only
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        run  <= 1'b0;
        mode <= 1'b0;
        ie   <= 1'b0;
      end else if (hit && reg_sel == 2'd0 && bus.wstrb[0]) begin
        run  <= bus.wdata[0];
        mode <= bus.wdata[2];
        ie   <= bus.wdata[3];
      end
    end

    // compare register with byte-lane merge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cmp <= '1;
      else if (hit && reg_sel == 2'd1)
        cmp <= (cmp & ~bmask[CNT_W-1:0])
             | wd_m[CNT_W-1:0];
    end

    // counter and sticky flags; hardware set beats W1C
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        m_f <= 1'b0;
        o_f <= 1'b0;
      end else begin
        if (clr)
          cnt <= '0;
        else if (tick)
          cnt <= (mode && match) ? '0 : cnt + CNT_W'(1);
        m_f <= (adv && match) | (m_f & ~w1c[0]);
        o_f <= (adv && !(mode && match) && (&cnt))
             | (o_f & ~w1c[1]);
      end
    end

    assign ctrl_v = {presc, 4'b0, ie, mode, 1'b0, run};
    assign irq[c] = ie && (m_f || o_f);

    // register read decode for this channel
    always_comb begin
      rd_v = '0;
      unique case (1'b1)
        reg_sel == 2'd0: rd_v = DATA_W'(ctrl_v);
        reg_sel == 2'd1: rd_v = DATA_W'(cmp);
        reg_sel == 2'd2: rd_v = DATA_W'(cnt);
        reg_sel == 2'd3: rd_v = DATA_W'({o_f, m_f});
      endcase
    end

    assign rd_ch[c] = (ch_idx == ADDR_W'(c)) ? rd_v : '0;
  end

  // combine channel read values; unmatched channels give 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++)
      rd_mux = rd_mux | rd_ch[i];
  end

  // one-cycle acknowledge with registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= bus.valid;
      if (bus.valid)
        bus.rdata <= wr ? '0 : rd_mux;
    end
  end
endmodule

// File: tb/tb_iob_timer_mc.sv
// tb_iob_timer_mc: table-driven bench with a response scoreboard.
// Two instances share the bus: CNT_W=32 (a) and CNT_W=8 (b).
module tb_iob_timer_mc;
  localparam int AW = 4;
  localparam int R_CTRL = 0;
  localparam int R_CMP  = 1;
  localparam int R_CNT  = 2;
  localparam int R_ST   = 3;
  localparam logic [3:0] W  = 4'hF;
  localparam logic [3:0] RD = 4'h0;
`ifdef TIMER_PRESC_EN
  localparam bit PRESC = 1'b1;
`else
  localparam bit PRESC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic [2:0]    irq_a;
  logic [2:0]    irq_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
    bit          rd;
    int          cyc;
    string       nm;
  } exp_t;

  typedef struct {
    int          ch;
    int          r;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  exp_t sb[$];
  vec_t tv[$];
  exp_t e;

  iob_timer_mc_if #(.DATA_W(32), .ADDR_W(AW)) bus_a ();
  iob_timer_mc_if #(.DATA_W(32), .ADDR_W(AW)) bus_b ();

  assign bus_a.valid   = valid;
  assign bus_a.address = address;
  assign bus_a.wdata   = wdata;
  assign bus_a.wstrb   = wstrb;
  assign bus_b.valid   = valid;
  assign bus_b.address = address;
  assign bus_b.wdata   = wdata;
  assign bus_b.wstrb   = wstrb;

  iob_timer_mc #(
    .DATA_W(32), .N_CH(3), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .irq(irq_a)
  );

  iob_timer_mc #(
    .DATA_W(32), .N_CH(3), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .irq(irq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // pop one expectation per acknowledge
  always @(negedge clk) begin
    if (rst_n && (bus_a.ready || bus_b.ready)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ready: got 1 want 0");
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_rdy"},
            32'({bus_a.ready, bus_b.ready}), 32'd3);
        chk({e.nm, "_lat"}, 32'(cyc - e.cyc), 32'd1);
        if (e.rd) begin
          chk({e.nm, "_a"}, bus_a.rdata, e.ea);
          chk({e.nm, "_b"}, bus_b.rdata, e.eb);
        end
      end
    end
  end

  task automatic op(input int ch, input int r,
                    input logic [31:0] d,
                    input logic [3:0] s,
                    input logic [31:0] ea,
                    input logic [31:0] eb,
                    input string nm);
    exp_t x;
    @(negedge clk);
    valid   = 1'b1;
    address = AW'(ch * 4 + r);
    wdata   = d;
    wstrb   = s;
    x.ea  = ea;
    x.eb  = eb;
    x.rd  = (s == 4'h0);
    x.cyc = cyc;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      wstrb = '0;
    end
  endtask

  function automatic void add(input int ch, input int r,
                              input logic [31:0] d,
                              input logic [3:0] s,
                              input logic [31:0] ea,
                              input logic [31:0] eb);
    vec_t v;
    v.ch = ch;
    v.r  = r;
    v.d  = d;
    v.s  = s;
    v.ea = ea;
    v.eb = eb;
    tv.push_back(v);
  endfunction

  task automatic run_tv(input string nm);
    for (int i = 0; i < tv.size(); i++)
      op(tv[i].ch, tv[i].r, tv[i].d, tv[i].s,
         tv[i].ea, tv[i].eb, $sformatf("%s%0d", nm, i));
    tv.delete();
  endtask

  task automatic reset_regs(input string nm);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        add(c, r, 32'h0, RD,
            (r == 1 && c < 3) ? 32'hFFFF_FFFF : 32'h0,
            (r == 1 && c < 3) ? 32'h0000_00FF : 32'h0);
    run_tv(nm);
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'({bus_a.ready, bus_b.ready}), 32'd0);
    chk("rst_irq", 32'({irq_a, irq_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_regs("rst");

    // periodic reload on ch0
    add(0, R_CMP, 32'd9, W, 0, 0);
    add(0, R_CTRL, 32'hD, W, 0, 0);
    for (int j = 1; j <= 12; j++)
      add(0, R_CNT, 0, RD, (j - 1) % 10, (j - 1) % 10);
    add(0, R_ST, 0, RD, 32'd1, 32'd1);
    run_tv("per");
    idle(1);
    chk("per_irq_a", 32'(irq_a), 32'd1);
    chk("per_irq_b", 32'(irq_b), 32'd1);
    op(0, R_ST, 32'd1, W, 0, 0, "w1c0");
    idle(1);
    chk("w1c_irq_a", 32'(irq_a), 32'd0);
    chk("w1c_irq_b", 32'(irq_b), 32'd0);
    op(0, R_CTRL, 32'd0, W, 0, 0, "stop0");

    // W1C vs match, CLR vs tick, byte lanes, range
    add(2, R_CMP, 32'd0, W, 0, 0);
    add(2, R_CTRL, 32'h5, W, 0, 0);
    add(2, R_ST, 32'd1, W, 0, 0);
    add(2, R_ST, 0, RD, 32'd1, 32'd1);
    add(2, R_CNT, 0, RD, 32'd0, 32'd0);
    add(2, R_CTRL, 32'd0, W, 0, 0);
    add(2, R_ST, 32'd1, W, 0, 0);
    add(2, R_ST, 0, RD, 32'd0, 32'd0);
    add(2, R_CTRL, 32'h1, W, 0, 0);
    add(2, R_CNT, 0, RD, 32'd0, 32'd0);
    add(2, R_CNT, 0, RD, 32'd1, 32'd1);
    add(2, R_CNT, 0, RD, 32'd2, 32'd2);
    add(2, R_CTRL, 32'h3, W, 0, 0);
    add(2, R_CNT, 0, RD, 32'd0, 32'd0);
    add(2, R_CNT, 0, RD, 32'd1, 32'd1);
    add(2, R_CTRL, 0, RD, 32'd1, 32'd1);
    add(2, R_CTRL, 32'd0, W, 0, 0);
    add(2, R_CMP, 32'hAABB_CCDD, 4'b0101, 0, 0);
    add(2, R_CMP, 0, RD, 32'h00BB_00DD, 32'hDD);
    add(2, R_CTRL, 32'hFF0D, 4'b0010, 0, 0);
    add(2, R_CTRL, 0, RD,
        PRESC ? 32'hFF00 : 32'h0, PRESC ? 32'hFF00 : 32'h0);
    add(2, R_CTRL, 32'd0, W, 0, 0);
    add(3, R_CMP, 32'h1234_5678, W, 0, 0);
    add(3, R_CMP, 0, RD, 32'd0, 32'd0);
    add(3, R_CTRL, 0, RD, 32'd0, 32'd0);
    add(0, R_CMP, 0, RD, 32'd9, 32'd9);
    run_tv("race");

    // free-run wrap on ch1: 8-bit instance overflows
    add(1, R_CTRL, 32'h1, W, 0, 0);
    run_tv("ovf_go");
    idle(252);
    add(1, R_CNT, 0, RD, 32'd252, 32'd252);
    add(1, R_CNT, 0, RD, 32'd253, 32'd253);
    add(1, R_ST, 0, RD, 32'd0, 32'd0);
    add(1, R_CNT, 0, RD, 32'd255, 32'd255);
    add(1, R_CNT, 0, RD, 32'd256, 32'd0);
    add(1, R_ST, 0, RD, 32'd0, 32'd3);
    add(1, R_CTRL, 32'd0, W, 0, 0);
    add(1, R_ST, 32'd3, W, 0, 0);
    add(1, R_CTRL, 32'h7, W, 0, 0);
    run_tv("ovf");
    chk("ovf_irq_b", 32'(irq_b), 32'd0);

    // reload at all-ones compare: match wins, no OVF
    idle(254);
    add(1, R_CNT, 0, RD, 32'd254, 32'd254);
    add(1, R_CNT, 0, RD, 32'd255, 32'd255);
    add(1, R_CNT, 0, RD, 32'd256, 32'd0);
    add(1, R_ST, 0, RD, 32'd0, 32'd1);
    add(1, R_CTRL, 32'd0, W, 0, 0);
    run_tv("top");

    // prescaler: PRESC=3 gives one tick per 4 cycles
    add(0, R_CTRL, 32'h303, W, 0, 0);
    for (int j = 1; j <= 9; j++)
      add(0, R_CNT, 0, RD,
          PRESC ? (j - 1) / 4 : j - 1,
          PRESC ? (j - 1) / 4 : j - 1);
    add(0, R_CTRL, 0, RD,
        PRESC ? 32'h301 : 32'h1, PRESC ? 32'h301 : 32'h1);
    add(0, R_CTRL, 32'd0, W, 0, 0);
    run_tv("psc");

    // interrupt pending, then reset mid-run
    op(2, R_CMP, 32'd0, W, 0, 0, "irq_cmp");
    op(2, R_CTRL, 32'hD, W, 0, 0, "irq_go");
    idle(2);
    chk("run_irq_a", 32'(irq_a), 32'd4);
    chk("run_irq_b", 32'(irq_b), 32'd4);
    op(2, R_CTRL, 0, RD, 0, 0, "killed");
    @(posedge clk);
    #1;
    valid = 1'b0;
    wstrb = '0;
    chk("pre_rst_ready",
        32'({bus_a.ready, bus_b.ready}), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",
        32'({bus_a.ready, bus_b.ready}), 32'd0);
    chk("mid_rst_irq", 32'({irq_a, irq_b}), 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_regs("rst2");
    idle(3);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
